hook_motion_ctrl: RTL and testbench
===================================

HOOK_MOTION_CTRL -- requirements
Module: hook_motion_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 4, pixels moved per frame step (1..15).
REQ-002 SHALL have parameter TOP_Y, default 8, topmost hook row (non-zero).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port fire  in  1  launch request, sampled in IDLE only.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 SHALL have port base_x  in  9  hook anchor column, latched at launch.
REQ-008 SHALL have port base_y  in  8  hook anchor row, latched at launch.
REQ-009 SHALL have port hit  in  1  collision flag from game logic, any cycle.
REQ-010 SHALL have port draw_done  in  1  completion pulse from the downstream sprite drawer.
REQ-011 SHALL have port plot  out  1  one-cycle draw request to the sprite drawer.
REQ-012 SHALL have port x_out  out  9  sprite x to drawer (latched base_x).
REQ-013 SHALL have port y_out  out  8  sprite y to drawer (current hook row).
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port caught  out  1  one-cycle pulse when a hook returns after a hit.
REQ-016 SHALL have port err  out  1  sticky draw-timeout flag.

Function
REQ-017 SHALL implement states IDLE, EXT_WAIT, EXT_DRAW, RET_WAIT, RET_DRAW, FINISH.
REQ-018 IDLE: fire=1 -> latch base_x/base_y, hook_y<=base_y, clear hit_l, go EXT_WAIT; otherwise stay.
REQ-019 EXT_WAIT: frame_tick=1 -> hook_y<=(hook_y<TOP_Y+STEP) ? TOP_Y : hook_y-STEP, go EXT_DRAW.
REQ-020 EXT_DRAW: draw_done=1 -> RET_WAIT if hit_l=1 or hook_y==TOP_Y, else EXT_WAIT.
REQ-021 RET_WAIT: frame_tick=1 -> hook_y<=(hook_y+STEP>=base_y_l, 9-bit compare) ? base_y_l : hook_y+STEP, go RET_DRAW.
REQ-022 RET_DRAW: draw_done=1 -> FINISH if hook_y==base_y_l, else RET_WAIT.
REQ-023 FINISH: caught=hit_l for exactly one cycle, then IDLE unconditionally.
REQ-024 plot SHALL be 1 only in the first cycle of each EXT_DRAW/RET_DRAW visit.
REQ-025 x_out/y_out SHALL update on entry to a DRAW state and hold stable until draw_done.
REQ-026 hit_l SHALL set on hit=1 in EXT_WAIT or EXT_DRAW; hit is ignored in other states.
REQ-027 frame_tick in DRAW states SHALL be dropped; no backlog accumulated.
REQ-028 fire while busy=1 SHALL be ignored.
REQ-029 draw_done outside DRAW states SHALL be ignored.
REQ-030 draw_done in the same cycle as plot SHALL be honoured as completion.
REQ-031 base_x/base_y changes after launch SHALL not affect the current flight.

Reset
REQ-032 reset=1 at any clk edge SHALL force IDLE, including mid-DRAW.
REQ-033 Reset values: plot=0, busy=0, caught=0, err=0, x_out=0, y_out=0, hook_y=0, hit_l=0, watchdog=0.

Configuration
REQ-034 Macro HOOK_DRAW_TIMEOUT_EN defined: a 10-bit watchdog SHALL count cycles in a DRAW state.
- On reaching 1023 without draw_done, the watchdog SHALL act as draw_done and set err=1 (sticky until reset).
- The watchdog SHALL clear on entry to each DRAW state.
REQ-035 Macro undefined: no watchdog SHALL be built, err SHALL be tied 0, and DRAW states SHALL wait indefinitely.

Verification
REQ-036 base=(160,200), no hit, done 3 cycles after each plot -> 48 extend plots y=196..8, then 48 retract plots y=12..200, caught=0, then IDLE.
REQ-037 Same stimulus, hit pulsed during the 3rd extend draw -> y sequence 196,192,188,192,196,200, then caught=1 for exactly one cycle.
REQ-038 base_y=10 -> plots y=8 then y=10; saturation at both ends, no wrap.
REQ-039 fire held high, frame_tick asserted during DRAW -> no relaunch while busy, exactly one step per WAIT visit.
REQ-040 reset during EXT_DRAW -> next cycle busy=0, plot=0, y_out=0; a new fire launches normally.
REQ-041 HOOK_DRAW_TIMEOUT_EN defined and draw_done stuck 0 -> advance 1023 cycles after DRAW entry, err=1; macro undefined -> remains in EXT_DRAW and err=0.

Source files
------------

// File: rtl/hook_motion_ctrl.sv
// hook_motion_ctrl: frame-stepped hook launcher. On fire the hook moves up from its
// anchor row to TOP_Y (or until a hit), then back down to the anchor. Every position
// is handed to a downstream sprite drawer with a one-cycle plot strobe, and the
// controller waits for that drawer's draw_done before taking the next step.
// Optional build macro HOOK_DRAW_TIMEOUT_EN adds a draw-completion watchdog and a
// sticky err flag. When the macro is undefined, DRAW states wait indefinitely and
// err is tied low.
module hook_motion_ctrl #(
    parameter int unsigned STEP  = 4,
    parameter int unsigned TOP_Y = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       frame_tick,
    input  logic [8:0] base_x,
    input  logic [7:0] base_y,
    input  logic       hit,
    input  logic       draw_done,
    output logic       plot,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic       busy,
    output logic       caught,
    output logic       err
);

    localparam logic [7:0] StepW   = 8'(STEP);
    localparam logic [7:0] TopW    = 8'(TOP_Y);
    // Extend saturates once a full step would overshoot the top row.
    localparam logic [8:0] ExtSatW = 9'(TOP_Y + STEP);

    typedef enum logic [2:0] {
        StIdle,
        StExtWait,
        StExtDraw,
        StRetWait,
        StRetDraw,
        StFinish
    } state_e;

    state_e     state_q;
    state_e     state_d;

    logic [8:0] base_x_l;
    logic [7:0] base_y_l;
    logic [7:0] hook_y;
    logic [7:0] hook_y_d;
    logic       hit_l;
    logic       plot_q;
    logic [8:0] x_q;
    logic [7:0] y_q;
    logic       enter_draw;
    logic       done_eff;
    logic [8:0] ret_sum;

    // Retract target is compared in 9 bits so hook_y + STEP cannot wrap past 255.
    assign ret_sum    = {1'b0, hook_y} + {1'b0, StepW};

    // A DRAW state is entered exactly when a WAIT state sees a frame tick.
    assign enter_draw = ((state_q == StExtWait) || (state_q == StRetWait)) && frame_tick;

`ifdef HOOK_DRAW_TIMEOUT_EN
    logic       in_draw;
    logic [9:0] watchdog;
    logic       wd_expire;
    logic       err_q;

    assign in_draw   = (state_q == StExtDraw) || (state_q == StRetDraw);
    // Expire on the cycle the count reaches 1023 with no completion from the drawer.
    assign wd_expire = in_draw && !draw_done && (watchdog == 10'd1022);
    assign done_eff  = draw_done || wd_expire;
    assign err       = err_q;

    // Watchdog counts DRAW cycles, restarting on every DRAW entry; err is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            watchdog <= '0;
            err_q    <= 1'b0;
        end else begin
            if (enter_draw) begin
                watchdog <= '0;
            end else if (in_draw) begin
                watchdog <= watchdog + 10'd1;
            end
            if (wd_expire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign done_eff = draw_done;
    assign err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; draw_done only matters in DRAW states, fire only in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (fire) state_d = StExtWait;
            end
            StExtWait: begin
                if (frame_tick) state_d = StExtDraw;
            end
            StExtDraw: begin
                if (done_eff) begin
                    state_d = (hit_l || (hook_y == TopW)) ? StRetWait : StExtWait;
                end
            end
            StRetWait: begin
                if (frame_tick) state_d = StRetDraw;
            end
            StRetDraw: begin
                if (done_eff) begin
                    state_d = (hook_y == base_y_l) ? StFinish : StRetWait;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state and registered draw strobe.
    always_comb begin
        busy   = (state_q != StIdle);
        caught = (state_q == StFinish) && hit_l;
        plot   = plot_q;
    end

    assign x_out = x_q;
    assign y_out = y_q;

    // Next hook row: one saturating step per WAIT visit that sees a tick.
    always_comb begin
        hook_y_d = hook_y;
        case (state_q)
            StIdle: begin
                if (fire) hook_y_d = base_y;
            end
            StExtWait: begin
                if (frame_tick) begin
                    hook_y_d = ({1'b0, hook_y} < ExtSatW) ? TopW : (hook_y - StepW);
                end
            end
            StRetWait: begin
                if (frame_tick) begin
                    hook_y_d = (ret_sum >= {1'b0, base_y_l}) ? base_y_l : ret_sum[7:0];
                end
            end
            default: begin
                hook_y_d = hook_y;
            end
        endcase
    end

    // Flight datapath: anchor latch, hook row and hit latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_x_l <= '0;
            base_y_l <= '0;
            hook_y   <= '0;
            hit_l    <= 1'b0;
        end else begin
            hook_y <= hook_y_d;
            if ((state_q == StIdle) && fire) begin
                base_x_l <= base_x;
                base_y_l <= base_y;
                hit_l    <= 1'b0;
            end else if (((state_q == StExtWait) || (state_q == StExtDraw)) && hit) begin
                hit_l <= 1'b1;
            end
        end
    end

    // Drawer interface: coordinates captured on DRAW entry, plot high for that first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            plot_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            plot_q <= enter_draw;
            if (enter_draw) begin
                x_q <= base_x_l;
                y_q <= hook_y_d;
            end
        end
    end

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// tb_hook_motion_ctrl: randomized flights checked against a plain-arithmetic model of the
// hook path (list of plotted rows and the caught outcome).
module tb_hook_motion_ctrl;

    localparam int STEP  = 4;
    localparam int TOP_Y = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       fire;
    logic       frame_tick;
    logic [8:0] base_x;
    logic [7:0] base_y;
    logic       hit;
    logic       draw_done;
    logic       plot;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic       busy;
    logic       caught;
    logic       err;

    hook_motion_ctrl #(
        .STEP  (STEP),
        .TOP_Y (TOP_Y)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fire       (fire),
        .frame_tick (frame_tick),
        .base_x     (base_x),
        .base_y     (base_y),
        .hit        (hit),
        .draw_done  (draw_done),
        .plot       (plot),
        .x_out      (x_out),
        .y_out      (y_out),
        .busy       (busy),
        .caught     (caught),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_y[$];
    int obs_y[$];
    int n_ext_exp;
    bit exp_caught;
    int caught_cnt;
    int x_bad;
    int stab_bad;
    bit flight_timeout;

    // Reference: rows the hook should be plotted at, from the movement rules.
    function automatic void ref_flight(input int by, input int hit_idx);
        int y;
        int n;
        bit hf;
        exp_y.delete();
        y  = by;
        n  = 0;
        hf = 1'b0;
        do begin
            y = (y - STEP < TOP_Y) ? TOP_Y : y - STEP;
            exp_y.push_back(y);
            n++;
            if (n == hit_idx) hf = 1'b1;
        end while (!hf && y != TOP_Y);
        n_ext_exp  = n;
        exp_caught = hf;
        do begin
            y = (y + STEP > by) ? by : y + STEP;
            exp_y.push_back(y);
        end while (y != by);
    endfunction

    function automatic int first_diff();
        int k;
        k = -1;
        for (int i = 0; i < exp_y.size() && i < obs_y.size(); i++) begin
            if (k < 0 && obs_y[i] != exp_y[i]) k = i;
        end
        return k;
    endfunction

    // Launch one flight and act as the sprite drawer until the hook is back in IDLE.
    // dly < 0 picks a random 0..3 cycle draw latency; noisy holds fire, injects stray
    // draw_done outside draws and stray hits during retract draws.
    task automatic drive_flight(input logic [8:0] bx, input logic [7:0] by, input int hit_idx,
                                input int dly, input bit noisy);
        int         pend;
        bit         in_draw;
        bit         launched;
        bit         fin;
        int         nplots;
        logic [8:0] cx;
        logic [7:0] cy;
        obs_y.delete();
        caught_cnt     = 0;
        x_bad          = 0;
        stab_bad       = 0;
        flight_timeout = 1'b0;
        ref_flight(int'(by), hit_idx);
        @(negedge clk);
        base_x   = bx;
        base_y   = by;
        fire     = 1'b1;
        pend     = 0;
        in_draw  = 1'b0;
        launched = 1'b0;
        fin      = 1'b0;
        nplots   = 0;
        cx       = '0;
        cy       = '0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            @(negedge clk);
            if (!noisy) fire = 1'b0;
            base_x     = 9'($urandom);
            base_y     = 8'($urandom);
            frame_tick = ($urandom_range(0, 2) == 0);
            hit        = 1'b0;
            draw_done  = 1'b0;
            if (busy) launched = 1'b1;
            if (caught) caught_cnt++;
            if (plot) begin
                nplots++;
                obs_y.push_back(int'(y_out));
                if (x_out !== bx) x_bad++;
                cx      = x_out;
                cy      = y_out;
                in_draw = 1'b1;
                pend    = (dly >= 0) ? dly : int'($urandom_range(0, 3));
                if (nplots == hit_idx) begin
                    hit = 1'b1;
                    if (pend == 0) pend = 1;
                end else if (noisy && nplots > n_ext_exp && $urandom_range(0, 1) == 1) begin
                    hit = 1'b1;
                end
            end else if (in_draw) begin
                if (x_out !== cx || y_out !== cy) stab_bad++;
                pend--;
            end
            if (in_draw && pend == 0) begin
                draw_done = 1'b1;
                in_draw   = 1'b0;
                if (nplots == exp_y.size()) fire = 1'b0;
            end else if (!in_draw && noisy && $urandom_range(0, 3) == 0) begin
                draw_done = 1'b1;
            end
            if (launched && !busy && !in_draw) fin = 1'b1;
        end
        if (!fin) flight_timeout = 1'b1;
        fire       = 1'b0;
        frame_tick = 1'b0;
        draw_done  = 1'b0;
        hit        = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        fire       = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        draw_done  = 1'b0;
        base_x     = '0;
        base_y     = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (plot !== 1'b0) begin n_bad++; $display("FAIL reset_plot: got %b want 0", plot); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (caught !== 1'b0) begin n_bad++; $display("FAIL reset_caught: got %b want 0", caught); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (x_out !== 9'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", x_out); end
        n_cmp++; if (y_out !== 8'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", y_out); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_hold_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_flight();
        int k;
        drive_flight(9'd160, 8'd200, 0, 3, 1'b0);
        n_cmp++; if (flight_timeout) begin n_bad++; $display("FAIL full_timeout: got 1 want 0"); end
        n_cmp++; if (obs_y.size() != exp_y.size()) begin n_bad++; $display("FAIL full_count: got %0d want %0d", obs_y.size(), exp_y.size()); end
        k = first_diff();
        n_cmp++; if (k >= 0) begin n_bad++; $display("FAIL full_seq[%0d]: got %0d want %0d", k, obs_y[k], exp_y[k]); end
        n_cmp++; if (caught_cnt != 0) begin n_bad++; $display("FAIL full_caught: got %0d want 0", caught_cnt); end
        n_cmp++; if (x_bad != 0) begin n_bad++; $display("FAIL full_x: got %0d bad want 0", x_bad); end
        n_cmp++; if (stab_bad != 0) begin n_bad++; $display("FAIL full_stable: got %0d bad want 0", stab_bad); end
    endtask

    task automatic test_hit_return();
        int k;
        drive_flight(9'd160, 8'd200, 3, 3, 1'b0);
        n_cmp++; if (obs_y.size() != exp_y.size()) begin n_bad++; $display("FAIL hit_count: got %0d want %0d", obs_y.size(), exp_y.size()); end
        k = first_diff();
        n_cmp++; if (k >= 0) begin n_bad++; $display("FAIL hit_seq[%0d]: got %0d want %0d", k, obs_y[k], exp_y[k]); end
        n_cmp++; if (caught_cnt != 1) begin n_bad++; $display("FAIL hit_caught: got %0d cycles want 1", caught_cnt); end
    endtask

    task automatic test_saturation();
        logic [7:0] bys[4];
        int         k;
        bys = '{8'd10, 8'd3, 8'd255, 8'd8};
        foreach (bys[i]) begin
            drive_flight(9'($urandom), bys[i], 0, -1, 1'b0);
            n_cmp++; if (obs_y.size() != exp_y.size()) begin n_bad++; $display("FAIL sat_count by=%0d: got %0d want %0d", bys[i], obs_y.size(), exp_y.size()); end
            k = first_diff();
            n_cmp++; if (k >= 0) begin n_bad++; $display("FAIL sat_seq by=%0d [%0d]: got %0d want %0d", bys[i], k, obs_y[k], exp_y[k]); end
            n_cmp++; if (caught_cnt != 0) begin n_bad++; $display("FAIL sat_caught by=%0d: got %0d want 0", bys[i], caught_cnt); end
        end
    endtask

    task automatic test_fire_noise();
        int k;
        drive_flight(9'd300, 8'd90, 5, -1, 1'b1);
        n_cmp++; if (flight_timeout) begin n_bad++; $display("FAIL noise_timeout: got 1 want 0"); end
        n_cmp++; if (obs_y.size() != exp_y.size()) begin n_bad++; $display("FAIL noise_count: got %0d want %0d", obs_y.size(), exp_y.size()); end
        k = first_diff();
        n_cmp++; if (k >= 0) begin n_bad++; $display("FAIL noise_seq[%0d]: got %0d want %0d", k, obs_y[k], exp_y[k]); end
        n_cmp++; if (caught_cnt != 1) begin n_bad++; $display("FAIL noise_caught: got %0d want 1", caught_cnt); end
        n_cmp++; if (x_bad != 0) begin n_bad++; $display("FAIL noise_x: got %0d bad want 0", x_bad); end
    endtask

    task automatic test_random();
        int k;
        int hidx;
        for (int t = 0; t < 16; t++) begin
            hidx = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
            drive_flight(9'($urandom), 8'($urandom), hidx, -1, 1'($urandom_range(0, 1)));
            n_cmp++; if (obs_y.size() != exp_y.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", t, obs_y.size(), exp_y.size()); end
            k = first_diff();
            n_cmp++; if (k >= 0) begin n_bad++; $display("FAIL rnd%0d_seq[%0d]: got %0d want %0d", t, k, obs_y[k], exp_y[k]); end
            n_cmp++; if (caught_cnt != int'(exp_caught)) begin n_bad++; $display("FAIL rnd%0d_caught: got %0d want %0d", t, caught_cnt, exp_caught); end
            n_cmp++; if (stab_bad != 0 || x_bad != 0) begin n_bad++; $display("FAIL rnd%0d_xy: got %0d/%0d bad want 0/0", t, x_bad, stab_bad); end
        end
    endtask

    task automatic test_reset_mid_draw();
        bit seen;
        int k;
        @(negedge clk);
        base_x = 9'd77;
        base_y = 8'd120;
        fire   = 1'b1;
        @(negedge clk);
        fire       = 1'b0;
        frame_tick = 1'b1;
        seen       = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (plot) seen = 1'b1;
        end
        frame_tick = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_plot: got no plot want plot"); end
        n_cmp++; if (y_out !== 8'd116) begin n_bad++; $display("FAIL mid_y: got %0d want 116", y_out); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_cmp++; if (plot !== 1'b0) begin n_bad++; $display("FAIL mid_rst_plot: got %b want 0", plot); end
        n_cmp++; if (y_out !== 8'd0) begin n_bad++; $display("FAIL mid_rst_y: got %0d want 0", y_out); end
        drive_flight(9'd5, 8'd40, 0, -1, 1'b0);
        n_cmp++; if (obs_y.size() != exp_y.size()) begin n_bad++; $display("FAIL relaunch_count: got %0d want %0d", obs_y.size(), exp_y.size()); end
        k = first_diff();
        n_cmp++; if (k >= 0) begin n_bad++; $display("FAIL relaunch_seq[%0d]: got %0d want %0d", k, obs_y[k], exp_y[k]); end
    endtask

    task automatic test_watchdog();
        bit         seen;
        int         errlat;
        int         plot2_lat;
        logic [7:0] plot2_y;
        @(negedge clk);
        base_x = 9'd100;
        base_y = 8'd50;
        fire   = 1'b1;
        @(negedge clk);
        fire       = 1'b0;
        frame_tick = 1'b1;
        seen       = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (plot) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL wd_first_plot: got no plot want plot"); end
        errlat    = -1;
        plot2_lat = -1;
        plot2_y   = '0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (err === 1'b1 && errlat < 0) errlat = c;
            if (plot === 1'b1 && plot2_lat < 0) begin
                plot2_lat = c;
                plot2_y   = y_out;
            end
        end
`ifdef HOOK_DRAW_TIMEOUT_EN
        n_cmp++; if (errlat != 1023) begin n_bad++; $display("FAIL wd_err_latency: got %0d want 1023", errlat); end
        n_cmp++; if (plot2_lat != 1024) begin n_bad++; $display("FAIL wd_advance: got %0d want 1024", plot2_lat); end
        n_cmp++; if (plot2_y !== 8'd42) begin n_bad++; $display("FAIL wd_next_y: got %0d want 42", plot2_y); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: got %b want 1", err); end
`else
        n_cmp++; if (errlat != -1) begin n_bad++; $display("FAIL wd_err_off: got %0d want none", errlat); end
        n_cmp++; if (plot2_lat != -1) begin n_bad++; $display("FAIL wd_hold: got plot at %0d want none", plot2_lat); end
        n_cmp++; if (busy !== 1'b1 || y_out !== 8'd46) begin n_bad++; $display("FAIL wd_stuck: got busy=%b y=%0d want busy=1 y=46", busy, y_out); end
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        @(negedge clk);
        n_cmp++; if (plot !== 1'b1 || y_out !== 8'd42) begin n_bad++; $display("FAIL wd_resume: got plot=%b y=%0d want plot=1 y=42", plot, y_out); end
`endif
        frame_tick = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL wd_reset: got err=%b busy=%b want 0/0", err, busy); end
    endtask

    initial begin
        test_reset();
        test_full_flight();
        test_hit_return();
        test_saturation();
        test_fire_noise();
        test_random();
        test_reset_mid_draw();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
